bus_arbiter_rr: RTL and testbench

//  Two-master bus arbiter and transfer sequencer for the shared address/data bus.

---
 rtl/bus_pkg.sv | 36 +++
 rtl/arb_wait_timer.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 151 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the bus arbiter and datapath control:
// slave response codes, sequencer states and the round-robin pick.
package bus_pkg;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        ERR  = 2'b11
    } state_e;

    // Returns the owner index (0 = master 1, 1 = master 2) for a
    // non-empty eligibility vector; ties go to the non-last owner.
    function automatic logic rr_pick(
        input logic [1:0] elig,
        input logic       last
    );
        logic pick;
        pick = 1'b0;
        unique case (1'b1)
            (elig == 2'b01): pick = 1'b0;
            (elig == 2'b10): pick = 1'b1;
            (elig == 2'b11): pick = ~last;
            default:         pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// DATA-phase wait counter for the bus arbiter.
// expired flags the last tolerated not-ready cycle.
module arb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] wait_cnt_q;

    // Count not-ready DATA cycles; cleared on each address phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else if (clr) begin
            wait_cnt_q <= '0;
        end else if (en) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign expired = (wait_cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin bus arbiter and transfer sequencer.
// Handles RETRY, SPLIT, ERROR and ready timeout per transfer.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int RETRY_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busreq_1,
    input  logic       busreq_2,
    input  logic       ready,
    input  logic [1:0] response,
    input  logic [1:0] split_resume,
    output logic       grant_1,
    output logic       grant_2,
    output logic       owner,
    output logic       bus_busy,
    output logic       error,
    output logic       timeout
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    state_e        state_q;
    logic          last_owner_q;
    logic [1:0]    split_mask_q;
    logic [RW-1:0] retry_cnt_q;

    resp_e         resp;
    logic [1:0]    elig;
    logic          pick;
    logic          expired;
    logic          tmr_clr;
    logic          tmr_en;
    logic [1:0]    split_set;

    assign resp    = resp_e'(response);
    assign elig    = {busreq_2, busreq_1} & ~split_mask_q;
    assign pick    = rr_pick(elig, last_owner_q);
    assign tmr_clr = (state_q == ADDR);
    assign tmr_en  = (state_q == DATA) && (resp == OKAY) && !ready;

    assign split_set = ((state_q == DATA) && (resp == SPLIT))
                     ? (owner ? 2'b10 : 2'b01)
                     : 2'b00;

    arb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

    // Park split masters; a same-cycle SPLIT beats a resume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            split_mask_q <= 2'b00;
        end else begin
            split_mask_q <= (split_mask_q & ~split_resume) | split_set;
        end
    end

    // Transfer sequencer with registered grant/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            retry_cnt_q  <= '0;
            grant_1      <= 1'b0;
            grant_2      <= 1'b0;
            owner        <= 1'b0;
            bus_busy     <= 1'b0;
            error        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            error   <= 1'b0;
            timeout <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (elig != 2'b00) begin
                        owner       <= pick;
                        grant_1     <= ~pick;
                        grant_2     <= pick;
                        bus_busy    <= 1'b1;
                        retry_cnt_q <= '0;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    state_q <= DATA;
                end
                DATA: begin
                    unique case (resp)
                        OKAY: begin
                            if (ready) begin
                                last_owner_q <= owner;
                                grant_1      <= 1'b0;
                                grant_2      <= 1'b0;
                                bus_busy     <= 1'b0;
                                state_q      <= IDLE;
                            end else if (expired) begin
                                grant_1  <= 1'b0;
                                grant_2  <= 1'b0;
                                bus_busy <= 1'b0;
                                error    <= 1'b1;
                                timeout  <= 1'b1;
                                state_q  <= ERR;
                            end
                        end
                        ERROR: begin
                            grant_1  <= 1'b0;
                            grant_2  <= 1'b0;
                            bus_busy <= 1'b0;
                            error    <= 1'b1;
                            state_q  <= ERR;
                        end
                        RETRY: begin
                            if (retry_cnt_q == RW'(RETRY_MAX - 1)) begin
                                grant_1  <= 1'b0;
                                grant_2  <= 1'b0;
                                bus_busy <= 1'b0;
                                error    <= 1'b1;
                                state_q  <= ERR;
                            end else begin
                                retry_cnt_q <= retry_cnt_q + 1'b1;
                                state_q     <= ADDR;
                            end
                        end
                        SPLIT: begin
                            last_owner_q <= owner;
                            grant_1      <= 1'b0;
                            grant_2      <= 1'b0;
                            bus_busy     <= 1'b0;
                            state_q      <= IDLE;
                        end
                    endcase
                end
                ERR: begin
                    last_owner_q <= owner;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scoreboard bench for bus_arbiter_rr.
// Expected output vectors are queued per step and popped after the edge.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busreq_1;
    logic       busreq_2;
    logic       ready;
    logic [1:0] response;
    logic [1:0] split_resume;
    logic       grant_1;
    logic       grant_2;
    logic       owner;
    logic       bus_busy;
    logic       error;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    logic [5:0] sbq[$];

    // {grant_1, grant_2, owner, bus_busy, error, timeout}
    localparam logic [5:0] IDLE_O0 = 6'b000000;
    localparam logic [5:0] IDLE_O1 = 6'b001000;
    localparam logic [5:0] G1      = 6'b100100;
    localparam logic [5:0] G2      = 6'b011100;
    localparam logic [5:0] ERR_O0  = 6'b000010;
    localparam logic [5:0] TO_O0   = 6'b000011;

    localparam logic [1:0] R_OK = 2'b00;
    localparam logic [1:0] R_ER = 2'b01;
    localparam logic [1:0] R_RT = 2'b10;
    localparam logic [1:0] R_SP = 2'b11;

    bus_arbiter_rr dut (
        .clk         (clk),
        .rst         (rst_n),
        .busreq_1    (busreq_1),
        .busreq_2    (busreq_2),
        .ready       (ready),
        .response    (response),
        .split_resume(split_resume),
        .grant_1     (grant_1),
        .grant_2     (grant_2),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .error       (error),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {grant_1, grant_2, owner, bus_busy, error, timeout};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs.
    task automatic cyc(
        input string      tag,
        input logic       r1,
        input logic       r2,
        input logic       rdy,
        input logic [1:0] resp,
        input logic [1:0] sres,
        input logic [5:0] exp
    );
        busreq_1     = r1;
        busreq_2     = r2;
        ready        = rdy;
        response     = resp;
        split_resume = sres;
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        check(tag, sbq.pop_front());
    endtask

    task automatic do_reset();
        busreq_1     = 1'b0;
        busreq_2     = 1'b0;
        ready        = 1'b0;
        response     = R_OK;
        split_resume = 2'b00;
        rst_n        = 1'b0;
        #1;
        check("reset_async", IDLE_O0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        busreq_1     = 1'b0;
        busreq_2     = 1'b0;
        ready        = 1'b0;
        response     = R_OK;
        split_resume = 2'b00;
        @(posedge clk);
        #1;
        check("reset_state", IDLE_O0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single requester, immediate OKAY
        cyc("t1_addr", 1, 0, 1, R_OK, 2'b00, G1);
        cyc("t1_data", 0, 0, 1, R_OK, 2'b00, G1);
        cyc("t1_rel",  0, 0, 1, R_OK, 2'b00, IDLE_O0);
        cyc("t1_idle", 0, 0, 1, R_OK, 2'b00, IDLE_O0);

        // both requesting: 1,2,1,2 from reset
        do_reset();
        for (int r = 0; r < 2; r++) begin
            cyc("t2_m1_addr", 1, 1, 1, R_OK, 2'b00, G1);
            cyc("t2_m1_data", 1, 1, 1, R_OK, 2'b00, G1);
            cyc("t2_m1_rel",  1, 1, 1, R_OK, 2'b00, IDLE_O0);
            cyc("t2_m2_addr", 1, 1, 1, R_OK, 2'b00, G2);
            cyc("t2_m2_data", 1, 1, 1, R_OK, 2'b00, G2);
            cyc("t2_m2_rel",  r == 1 ? 1'b0 : 1'b1, r == 1 ? 1'b0 : 1'b1,
                1, R_OK, 2'b00, IDLE_O1);
        end

        // split of master 2, with a colliding resume that must lose
        cyc("t3_addr",  0, 1, 0, R_OK, 2'b00, G2);
        cyc("t3_data",  0, 1, 0, R_OK, 2'b00, G2);
        cyc("t3_split", 0, 1, 0, R_SP, 2'b10, IDLE_O1);
        for (int i = 0; i < 3; i++) begin
            cyc("t3_masked", 0, 1, 1, R_OK, 2'b00, IDLE_O1);
        end
        cyc("t3_m1_addr",      1, 1, 0, R_OK, 2'b00, G1);
        cyc("t3_m1_data",      1, 1, 0, R_OK, 2'b00, G1);
        cyc("t3_m1_rel",       0, 1, 1, R_OK, 2'b00, IDLE_O0);
        cyc("t3_still_masked", 0, 1, 1, R_OK, 2'b00, IDLE_O0);
        cyc("t3_resume",       0, 1, 1, R_OK, 2'b10, IDLE_O0);
        cyc("t3_m2_addr",      0, 1, 1, R_OK, 2'b00, G2);
        cyc("t3_m2_data",      0, 0, 1, R_OK, 2'b00, G2);
        cyc("t3_m2_rel",       0, 0, 1, R_OK, 2'b00, IDLE_O1);

        // RETRY every DATA cycle: three re-issues, then abort
        cyc("t4_addr", 1, 0, 0, R_OK, 2'b00, G1);
        cyc("t4_data", 0, 0, 0, R_OK, 2'b00, G1);
        for (int i = 0; i < 3; i++) begin
            cyc("t4_retry",  0, 0, 0, R_RT, 2'b00, G1);
            cyc("t4_readdr", 0, 0, 0, R_OK, 2'b00, G1);
        end
        cyc("t4_abort", 0, 0, 0, R_RT, 2'b00, ERR_O0);
        cyc("t4_idle",  0, 0, 0, R_OK, 2'b00, IDLE_O0);

        // slave ERROR response aborts without timeout
        cyc("t4e_addr",  1, 0, 0, R_OK, 2'b00, G1);
        cyc("t4e_data",  0, 0, 0, R_OK, 2'b00, G1);
        cyc("t4e_error", 0, 0, 0, R_ER, 2'b00, ERR_O0);
        cyc("t4e_idle",  0, 0, 0, R_OK, 2'b00, IDLE_O0);

        // ready held low: timeout 16 cycles after entering DATA
        cyc("t5_addr", 1, 0, 0, R_OK, 2'b00, G1);
        cyc("t5_data", 0, 0, 0, R_OK, 2'b00, G1);
        for (int i = 0; i < 15; i++) begin
            cyc("t5_wait", 0, 0, 0, R_OK, 2'b00, G1);
        end
        cyc("t5_timeout", 0, 0, 0, R_OK, 2'b00, TO_O0);
        cyc("t5_idle",    0, 0, 0, R_OK, 2'b00, IDLE_O0);

        // reset mid-DATA: async clear, no error, then master 1 wins
        cyc("t6_addr", 0, 1, 0, R_OK, 2'b00, G2);
        cyc("t6_data", 0, 1, 0, R_OK, 2'b00, G2);
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", IDLE_O0);
        @(posedge clk);
        #1;
        check("t6_in_reset", IDLE_O0);
        rst_n = 1'b1;
        cyc("t6_m1_addr", 1, 1, 1, R_OK, 2'b00, G1);
        cyc("t6_m1_data", 0, 0, 1, R_OK, 2'b00, G1);
        cyc("t6_m1_rel",  0, 0, 1, R_OK, 2'b00, IDLE_O0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
